cnt_mod: RTL and testbench

Parametrised modulo-N up/down counter: the next generation of the fixed mod-12 up/down counter, generalised in width and modulus. Over the fixed counter it adds:
- count enable
- synchronous parallel load with range checking
- a selectable wrap or saturate mode
- a combinational terminal-count output for cascading stages
- a registered wrap pulse

It is the standard counter primitive for timers, dividers and cascaded multi-digit counters in the design.

---
 rtl/cnt_mod.sv | 95 +++++++++
 tb/tb_cnt_mod.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_mod.sv
// Parametrised modulo-N up/down counter with load, wrap/saturate mode,
// combinational terminal count for cascading and a registered wrap pulse.
module cnt_mod #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 12,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             ud,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             err
);

    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("cnt_mod: WIDTH must be 1..16");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_mod
        $error("cnt_mod: MODULUS must be 2..2**WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_rst
        $error("cnt_mod: RESET_VAL must be below MODULUS");
    end

    // One extra bit so that MODULUS == 2**WIDTH is representable
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST   = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] q_n;
    logic             wrap_n;
    logic             err_n;
    logic             at_max;
    logic             at_min;
    logic             din_bad;

    assign at_max  = (q == MAX);
    assign at_min  = (q == '0);
    assign din_bad = ({1'b0, din} >= MOD_W);
    assign tc      = en & ~load & ~sat & (ud ? at_max : at_min);

    always_comb begin
        q_n    = q;
        wrap_n = 1'b0;
        err_n  = err;
        if (load) begin
            if (din_bad) begin
                q_n   = MAX;
                err_n = 1'b1;
            end else begin
                q_n = din;
            end
        end else if (en) begin
            if (ud) begin
                // Bound compare first, so q+1 never overflows WIDTH
                if (at_max) begin
                    if (!sat) begin
                        q_n    = '0;
                        wrap_n = 1'b1;
                    end
                end else begin
                    q_n = q + 1'b1;
                end
            end else begin
                if (at_min) begin
                    if (!sat) begin
                        q_n    = MAX;
                        wrap_n = 1'b1;
                    end
                end else begin
                    q_n = q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q    <= RST;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else begin
            q    <= q_n;
            wrap <= wrap_n;
            err  <= err_n;
        end
    end

endmodule

// File: tb/tb_cnt_mod.sv
// Directed self-checking bench for cnt_mod: default mod-12 instance,
// plus a cascaded mod-8 -> mod-16 pair and a 1-bit mod-2 instance.
module tb_cnt_mod;

    logic       clk = 1'b0;
    logic       reset, en, ud, sat, load;
    logic [3:0] din, q;
    logic       tc, wrap, err;

    logic       reset_c, en_a;
    logic [2:0] a_q;
    logic       a_tc, a_wrap, a_err;
    logic [3:0] b_q;
    logic       b_tc, b_wrap, b_err;
    logic [0:0] c_q;
    logic       c_tc, c_wrap, c_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cnt_mod u_dut (
        .clk(clk), .reset(reset), .en(en), .ud(ud), .sat(sat),
        .load(load), .din(din), .q(q), .tc(tc), .wrap(wrap), .err(err)
    );

    cnt_mod #(.WIDTH(3), .MODULUS(8), .RESET_VAL(5)) u_a (
        .clk(clk), .reset(reset_c), .en(en_a), .ud(1'b1), .sat(1'b0),
        .load(1'b0), .din(3'd0), .q(a_q), .tc(a_tc), .wrap(a_wrap),
        .err(a_err)
    );

    cnt_mod #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) u_b (
        .clk(clk), .reset(reset_c), .en(a_tc), .ud(1'b1), .sat(1'b0),
        .load(1'b0), .din(4'd0), .q(b_q), .tc(b_tc), .wrap(b_wrap),
        .err(b_err)
    );

    cnt_mod #(.WIDTH(1), .MODULUS(2), .RESET_VAL(0)) u_c (
        .clk(clk), .reset(reset_c), .en(en_a), .ud(1'b1), .sat(1'b0),
        .load(1'b0), .din(1'b0), .q(c_q), .tc(c_tc), .wrap(c_wrap),
        .err(c_err)
    );

    task automatic test_reset();
        reset = 1'b0; en = 1'b0; ud = 1'b1; sat = 1'b0;
        load = 1'b0; din = 4'd0;
        #3;
        n_cmp++;
        if ({q, wrap, err} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_state q=%0d wrap=%b err=%b want 0/0/0",
                     q, wrap, err);
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_count_up();
        int exp_q[15] = '{1,2,3,4,5,6,7,8,9,10,11,0,1,2,3};
        logic exp_tc;
        en = 1'b1; ud = 1'b1; sat = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            exp_tc = (i == 11);
            n_cmp++;
            if (tc !== exp_tc) begin
                n_bad++;
                $display("FAIL up_tc step %0d got %b want %b", i, tc, exp_tc);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (q !== 4'(exp_q[i]) || wrap !== (i == 11)) begin
                n_bad++;
                $display("FAIL up_q step %0d got q=%0d wrap=%b want %0d/%b",
                         i, q, wrap, exp_q[i], (i == 11));
            end
        end
    endtask

    task automatic test_count_down();
        int exp_q[6] = '{2,1,0,11,10,9};
        logic exp_tc;
        ud = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_tc = (i == 3);
            n_cmp++;
            if (tc !== exp_tc) begin
                n_bad++;
                $display("FAIL dn_tc step %0d got %b want %b", i, tc, exp_tc);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (q !== 4'(exp_q[i]) || wrap !== (i == 3)) begin
                n_bad++;
                $display("FAIL dn_q step %0d got q=%0d wrap=%b want %0d/%b",
                         i, q, wrap, exp_q[i], (i == 3));
            end
        end
    endtask

    task automatic test_saturate();
        load = 1'b1; din = 4'd10;
        @(posedge clk); #1;
        load = 1'b0; sat = 1'b1; ud = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (tc !== 1'b0) begin
                n_bad++;
                $display("FAIL sat_up_tc step %0d got %b want 0", i, tc);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (q !== 4'd11 || wrap !== 1'b0) begin
                n_bad++;
                $display("FAIL sat_up step %0d got q=%0d wrap=%b want 11/0",
                         i, q, wrap);
            end
        end
        load = 1'b1; din = 4'd1;
        @(posedge clk); #1;
        load = 1'b0; ud = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (q !== 4'd0 || wrap !== 1'b0 || tc !== 1'b0) begin
                n_bad++;
                $display("FAIL sat_dn step %0d got q=%0d wrap=%b tc=%b want 0/0/0",
                         i, q, wrap, tc);
            end
        end
        sat = 1'b0;
    endtask

    task automatic test_load();
        int ld_din[5] = '{7, 11, 12, 14, 3};
        int ld_q[5]   = '{7, 11, 11, 11, 3};
        int ld_err[5] = '{0, 0, 1, 1, 1};
        en = 1'b1; ud = 1'b1; load = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 4'(ld_din[i]);
            #1;
            n_cmp++;
            if (tc !== 1'b0) begin
                n_bad++;
                $display("FAIL load_tc step %0d got %b want 0", i, tc);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (q !== 4'(ld_q[i]) || wrap !== 1'b0 ||
                err !== 1'(ld_err[i])) begin
                n_bad++;
                $display("FAIL load din=%0d got q=%0d wrap=%b err=%b want %0d/0/%0d",
                         ld_din[i], q, wrap, err, ld_q[i], ld_err[i]);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_async_reset();
        load = 1'b1; din = 4'd0;
        @(posedge clk); #1;
        load = 1'b0; en = 1'b1; ud = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (q !== 4'd6 || err !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset got q=%0d err=%b want 6/1", q, err);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (q !== 4'd0 || wrap !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset got q=%0d wrap=%b err=%b want 0/0/0",
                     q, wrap, err);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (q !== 4'(i)) begin
                n_bad++;
                $display("FAIL resume step %0d got q=%0d want %0d", i, q, i);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_cascade();
        int a_e = 5;
        int b_e = 0;
        int c_e = 0;
        logic wa, wc;
        #1;
        n_cmp++;
        if (a_q !== 3'd5 || b_q !== 4'd0 || c_q !== 1'b0) begin
            n_bad++;
            $display("FAIL casc_reset got a=%0d b=%0d c=%0d want 5/0/0",
                     a_q, b_q, c_q);
        end
        reset_c = 1'b1; en_a = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            n_cmp++;
            if (a_tc !== (a_e == 7) || c_tc !== (c_e == 1)) begin
                n_bad++;
                $display("FAIL casc_tc step %0d got a_tc=%b c_tc=%b want %b/%b",
                         i, a_tc, c_tc, (a_e == 7), (c_e == 1));
            end
            @(posedge clk); #1;
            wa  = (a_e == 7);
            a_e = wa ? 0 : a_e + 1;
            b_e = wa ? (b_e + 1) % 16 : b_e;
            wc  = (c_e == 1);
            c_e = 1 - c_e;
            n_cmp++;
            if (a_q !== 3'(a_e) || a_wrap !== wa || b_q !== 4'(b_e) ||
                c_q !== 1'(c_e) || c_wrap !== wc) begin
                n_bad++;
                $display("FAIL casc step %0d got a=%0d aw=%b b=%0d c=%0d cw=%b want %0d/%b/%0d/%0d/%b",
                         i, a_q, a_wrap, b_q, c_q, c_wrap,
                         a_e, wa, b_e, c_e, wc);
            end
        end
        n_cmp++;
        if (a_q !== 3'd1 || b_q !== 4'd3) begin
            n_bad++;
            $display("FAIL casc_final got a=%0d b=%0d want 1/3", a_q, b_q);
        end
    endtask

    initial begin
        reset_c = 1'b0; en_a = 1'b0;
        test_reset();
        test_count_up();
        test_count_down();
        test_saturate();
        test_load();
        test_async_reset();
        test_cascade();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
